// File: rtl/instruction_assembler_pkg.sv
// Shared definitions for the instruction assembler: FSM states, beat-index
// mode selectors and the beat-select width helper.
package instruction_assembler_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    localparam int MODE_ADDR = 0;
    localparam int MODE_SEQ  = 1;

    // Width of a beat index: clog2(beats), but never narrower than one bit.
    function automatic int sel_width(input int beats);
        return (beats > 2) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/beat_tracker.sv
// Tracks which beat slot the next accepted Write lands in and whether that
// Write completes the instruction. In sequenced mode a wrapping counter picks
// the slot; in addressed mode Sel picks it and a fill mask records progress.
module beat_tracker
    import instruction_assembler_pkg::*;
#(
    parameter int BEATS    = 2,
    parameter int SEQ_MODE = MODE_SEQ,
    localparam int SEL_W   = sel_width(BEATS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             take,
    input  logic             restart,
    input  logic [SEL_W-1:0] sel,
    output logic [SEL_W-1:0] slot,
    output logic             complete,
    output logic [SEL_W-1:0] beat_idx
);

    if (SEQ_MODE == MODE_SEQ) begin : g_seq
        logic [SEL_W-1:0] cnt;
        logic             unused_sel;

        assign unused_sel = ^sel;
        assign beat_idx   = cnt;

        // A restarting take always lands in beat 0; the last beat completes.
        always_comb begin
            slot     = restart ? '0 : cnt;
            complete = take && (slot == SEL_W'(BEATS - 1));
        end

        // Advance on each stored beat, wrapping after the last one.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt <= '0;
            end else if (take) begin
                cnt <= complete ? '0 : slot + SEL_W'(1);
            end else if (restart) begin
                cnt <= '0;
            end
        end
    end else begin : g_addr
        logic [BEATS-1:0] mask;
        logic [BEATS-1:0] mask_next;
        int               filled;

        // Merge the addressed beat into the (possibly cleared) fill mask.
        always_comb begin
            mask_next = restart ? '0 : mask;
            if (take) begin
                for (int unsigned i = 0; i < BEATS; i++) begin
                    if (sel == SEL_W'(i)) begin
                        mask_next[i] = 1'b1;
                    end
                end
            end
            slot     = sel;
            complete = take && (&mask_next);
        end

        // Fill mask register.
        always_ff @(posedge clk) begin
            if (reset) begin
                mask <= '0;
            end else begin
                mask <= mask_next;
            end
        end

        // Report the number of filled beats, saturating at BEATS-1.
        always_comb begin
            filled = 0;
            for (int unsigned i = 0; i < BEATS; i++) begin
                filled = filled + int'(mask[i]);
            end
            beat_idx = (filled >= BEATS - 1) ? SEL_W'(BEATS - 1) : SEL_W'(filled);
        end
    end

endmodule

// File: rtl/instruction_assembler.sv
// Assembles BEATS bus-width beats into one instruction register and holds it
// as Valid until Consume. BEATS is expected to lie in 2..8.
module instruction_assembler
    import instruction_assembler_pkg::*;
#(
    parameter int BUS_W    = 8,
    parameter int BEATS    = 2,
    parameter int SEQ_MODE = MODE_SEQ,
    localparam int SEL_W   = sel_width(BEATS),
    localparam int IR_W    = BUS_W * BEATS
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [BUS_W-1:0] I,
    input  logic             Write,
    input  logic [SEL_W-1:0] Sel,
    input  logic             Consume,
    output logic [IR_W-1:0]  IROut,
    output logic             Valid,
    output logic [SEL_W-1:0] BeatIdx,
    output logic             Drop
);

    state_t           state;
    state_t           state_next;
    logic             consume_now;
    logic             sel_ok;
    logic             accept;
    logic             complete;
    logic [SEL_W-1:0] slot;
    logic [IR_W-1:0]  ir;
    logic             drop_q;

    // Consuming in FULL frees the register in the same edge, so a Write
    // arriving alongside Consume is taken as the first beat of the next one.
    assign consume_now = (state == FULL) && Consume;
    assign sel_ok      = (SEQ_MODE == MODE_SEQ) || (int'(Sel) < BEATS);
    assign accept      = Write && sel_ok && ((state == COLLECT) || Consume);

    beat_tracker #(
        .BEATS    (BEATS),
        .SEQ_MODE (SEQ_MODE)
    ) u_tracker (
        .clk      (Clock),
        .reset    (Reset),
        .take     (accept),
        .restart  (consume_now),
        .sel      (Sel),
        .slot     (slot),
        .complete (complete),
        .beat_idx (BeatIdx)
    );

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fill up in COLLECT, hold in FULL until consumed.
    always_comb begin
        state_next = state;
        unique case (state)
            COLLECT: begin
                if (accept && complete) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (Consume) begin
                    state_next = (accept && complete) ? FULL : COLLECT;
                end
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        Valid = (state == FULL);
    end

    // Instruction data path: store the accepted beat into its slot.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ir <= '0;
        end else if (accept) begin
            ir[slot*BUS_W +: BUS_W] <= I;
        end
    end

    // Flag any Write that was not accepted, for exactly the following cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= Write && !accept;
        end
    end

    assign IROut = ir;
    assign Drop  = drop_q;

endmodule

// File: tb/tb_instruction_assembler.sv
// Self-checking bench: four assembler configurations driven one at a time,
// a behavioural model predicting each cycle, and a scoreboard queue of
// expected outputs compared after every clock edge.
module tb_instruction_assembler;
    import instruction_assembler_pkg::*;

    localparam int N = 4;
    localparam int BEATS_OF [N] = '{2, 4, 2, 3};
    localparam int SEQ_OF   [N] = '{1, 1, 0, 0};

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [7:0] I     = '0;
    logic [1:0] Sel   = '0;
    logic       wr    [N];
    logic       cons  [N];
    logic       valid [N];
    logic       drop  [N];

    logic [15:0] ir0;
    logic [31:0] ir1;
    logic [15:0] ir2;
    logic [23:0] ir3;
    logic [0:0]  idx0;
    logic [1:0]  idx1;
    logic [0:0]  idx2;
    logic [1:0]  idx3;

    always #5 Clock = ~Clock;

    instruction_assembler #(.BUS_W(8), .BEATS(2), .SEQ_MODE(MODE_SEQ)) u_s2 (
        .Clock(Clock), .Reset(Reset), .I(I), .Write(wr[0]), .Sel(Sel[0:0]),
        .Consume(cons[0]), .IROut(ir0), .Valid(valid[0]), .BeatIdx(idx0), .Drop(drop[0]));
    instruction_assembler #(.BUS_W(8), .BEATS(4), .SEQ_MODE(MODE_SEQ)) u_s4 (
        .Clock(Clock), .Reset(Reset), .I(I), .Write(wr[1]), .Sel(Sel),
        .Consume(cons[1]), .IROut(ir1), .Valid(valid[1]), .BeatIdx(idx1), .Drop(drop[1]));
    instruction_assembler #(.BUS_W(8), .BEATS(2), .SEQ_MODE(MODE_ADDR)) u_a2 (
        .Clock(Clock), .Reset(Reset), .I(I), .Write(wr[2]), .Sel(Sel[0:0]),
        .Consume(cons[2]), .IROut(ir2), .Valid(valid[2]), .BeatIdx(idx2), .Drop(drop[2]));
    instruction_assembler #(.BUS_W(8), .BEATS(3), .SEQ_MODE(MODE_ADDR)) u_a3 (
        .Clock(Clock), .Reset(Reset), .I(I), .Write(wr[3]), .Sel(Sel),
        .Consume(cons[3]), .IROut(ir3), .Valid(valid[3]), .BeatIdx(idx3), .Drop(drop[3]));

    // Reference model state, one slot per configuration.
    logic [31:0] m_ir   [N];
    logic        m_full [N];
    int          m_cnt  [N];
    logic [7:0]  m_mask [N];
    logic        m_drop [N];

    typedef struct {
        int          d;
        logic [31:0] ir;
        logic        valid;
        logic [31:0] idx;
        logic        drop;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_ir(input int d);
        case (d)
            0:       return {16'h0, ir0};
            1:       return ir1;
            2:       return {16'h0, ir2};
            default: return {8'h0, ir3};
        endcase
    endfunction

    function automatic logic [31:0] dut_idx(input int d);
        case (d)
            0:       return {31'h0, idx0};
            1:       return {30'h0, idx1};
            2:       return {31'h0, idx2};
            default: return {30'h0, idx3};
        endcase
    endfunction

    function automatic logic [31:0] model_idx(input int d);
        int n;
        if (SEQ_OF[d] == 1) return m_cnt[d];
        n = $countones(m_mask[d]);
        return (n > BEATS_OF[d] - 1) ? BEATS_OF[d] - 1 : n;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < N; d++) begin
            m_ir[d] = '0; m_full[d] = 1'b0; m_cnt[d] = 0; m_mask[d] = '0; m_drop[d] = 1'b0;
        end
    endtask

    task automatic model_step(input int d, input logic w, input logic c,
                              input int s, input logic [7:0] data);
        logic refused;
        int   slot;
        refused = 1'b0;
        if (m_full[d]) begin
            if (c) begin
                m_full[d] = 1'b0; m_cnt[d] = 0; m_mask[d] = '0;
            end else if (w) begin
                refused = 1'b1;
            end
        end
        if (w && !refused) begin
            if (SEQ_OF[d] == 0 && s >= BEATS_OF[d]) begin
                refused = 1'b1;
            end else begin
                slot = (SEQ_OF[d] == 1) ? m_cnt[d] : s;
                m_ir[d][slot*8 +: 8] = data;
                if (SEQ_OF[d] == 1) begin
                    m_cnt[d]++;
                    if (m_cnt[d] == BEATS_OF[d]) begin
                        m_cnt[d] = 0; m_full[d] = 1'b1;
                    end
                end else begin
                    m_mask[d][slot] = 1'b1;
                    if (m_mask[d] == 8'((1 << BEATS_OF[d]) - 1)) m_full[d] = 1'b1;
                end
            end
        end
        m_drop[d] = refused;
    endtask

    task automatic push_expected(input int d);
        exp_t e;
        e.d = d; e.ir = m_ir[d]; e.valid = m_full[d]; e.idx = model_idx(d); e.drop = m_drop[d];
        sb.push_back(e);
    endtask

    task automatic compare_all();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq($sformatf("d%0d IROut", e.d),   dut_ir(e.d),        e.ir);
            check_eq($sformatf("d%0d Valid", e.d),   32'(valid[e.d]),    32'(e.valid));
            check_eq($sformatf("d%0d BeatIdx", e.d), dut_idx(e.d),       e.idx);
            check_eq($sformatf("d%0d Drop", e.d),    32'(drop[e.d]),     32'(e.drop));
        end
    endtask

    // Reset all DUTs; optionally hold Write/Consume high to show reset wins.
    task automatic do_reset(input logic busy);
        Reset = 1'b1; I = 8'hFF;
        for (int d = 0; d < N; d++) begin
            wr[d] = busy; cons[d] = busy;
        end
        model_reset();
        for (int d = 0; d < N; d++) push_expected(d);
        @(posedge Clock); #1;
        Reset = 1'b0;
        for (int d = 0; d < N; d++) begin
            wr[d] = 1'b0; cons[d] = 1'b0;
        end
        compare_all();
    endtask

    task automatic step(input int d, input logic w, input logic c,
                        input int s, input logic [7:0] data);
        I = data; Sel = 2'(s); wr[d] = w; cons[d] = c;
        model_step(d, w, c, s, data);
        push_expected(d);
        @(posedge Clock); #1;
        wr[d] = 1'b0; cons[d] = 1'b0;
        compare_all();
    endtask

    initial begin
        for (int d = 0; d < N; d++) begin
            wr[d] = 1'b0; cons[d] = 1'b0;
        end
        do_reset(1'b0);

        // Two-beat sequenced: low byte first.
        step(0, 1, 0, 0, 8'h34);
        step(0, 1, 0, 0, 8'h12);
        check_eq("s2 ir 1234", dut_ir(0), 32'h1234);
        step(0, 1, 0, 0, 8'h99);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 8'h00);

        // Four-beat sequenced: refuse while full, then consume with a write.
        step(1, 1, 0, 0, 8'hAA);
        step(1, 1, 0, 0, 8'hBB);
        step(1, 1, 0, 0, 8'hCC);
        step(1, 1, 0, 0, 8'hDD);
        step(1, 1, 0, 0, 8'h55);
        check_eq("s4 drop pulse", 32'(drop[1]), 32'h1);
        step(1, 0, 0, 0, 8'h00);
        step(1, 1, 1, 0, 8'h11);
        check_eq("s4 ir after consume", dut_ir(1), 32'hDDCCBB11);
        step(1, 0, 1, 0, 8'h00);

        // Two-beat addressed: rewriting a filled beat does not complete it.
        step(2, 1, 0, 1, 8'hAB);
        step(2, 1, 0, 1, 8'hCD);
        step(2, 1, 0, 0, 8'hEF);
        check_eq("a2 ir cdef", dut_ir(2), 32'hCDEF);
        step(2, 1, 1, 1, 8'h77);

        // Three-beat addressed: out-of-range select is refused.
        step(3, 1, 0, 3, 8'h5A);
        step(3, 0, 0, 0, 8'h00);
        step(3, 1, 0, 2, 8'h03);
        step(3, 1, 0, 0, 8'h01);
        step(3, 1, 0, 3, 8'h66);
        step(3, 1, 0, 1, 8'h02);
        check_eq("a3 ir 030201", dut_ir(3), 32'h030201);

        // Reset mid-collection, then a clean four-beat instruction.
        do_reset(1'b0);
        step(1, 1, 0, 0, 8'h01);
        step(1, 1, 0, 0, 8'h02);
        do_reset(1'b1);
        step(1, 1, 0, 0, 8'h0A);
        step(1, 1, 0, 0, 8'h0B);
        step(1, 1, 0, 0, 8'h0C);
        step(1, 1, 0, 0, 8'h0D);
        check_eq("s4 ir 0d0c0b0a", dut_ir(1), 32'h0D0C0B0A);

        // Random traffic on every configuration.
        for (int d = 0; d < N; d++) begin
            for (int k = 0; k < 40; k++) begin
                step(d, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                     (d == 2) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3)),
                     8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
